// File: rtl/ascon_pkg.sv
// Shared ASCON types and the forward/inverse 5-bit S-box constant tables.
// Bit 4 of a word is x0 (MSB) and bit 0 is x4.
package ascon_pkg;

  typedef logic [4:0] word_t;

  localparam int SBOX_ENTRIES = 32;

  localparam word_t SBOX_FWD [SBOX_ENTRIES] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  localparam word_t SBOX_INV [SBOX_ENTRIES] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

endpackage

// File: rtl/ascon_sbox_lut.sv
// Stateless ASCON S-box lookup (forward, plus inverse when ASCON_SBOX_INV_EN
// is defined).
module ascon_sbox_lut
  import ascon_pkg::*;
(
  input  logic [4:0] in,
`ifdef ASCON_SBOX_INV_EN
  input  logic       inv,
`endif
  output logic [4:0] out
);

  always_comb begin
    out = SBOX_FWD[in];
`ifdef ASCON_SBOX_INV_EN
    if (inv) begin
      out = SBOX_INV[in];
    end
`endif
  end

endmodule

// File: rtl/ascon_sbox.sv
// Registered ASCON 5-bit S-box, one result per accepted input, one cycle latency.
// Optional inverse map selected by `inv` when ASCON_SBOX_INV_EN is defined.
module ascon_sbox
  import ascon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in,
`ifdef ASCON_SBOX_INV_EN
  input  logic       inv,
`endif
  output logic       out_valid,
  output logic [4:0] out
);

  // Handshake: in_valid qualifies in/inv at a rising edge and is always
  // accepted (no ready); out_valid pulses for one cycle one edge later.
  word_t lut_out;
  word_t out_q, out_d;
  logic  out_valid_q, out_valid_d;

  ascon_sbox_lut u_lut (
    .in  (in),
`ifdef ASCON_SBOX_INV_EN
    .inv (inv),
`endif
    .out (lut_out)
  );

  // Idle cycles keep the last result so unqualified (possibly X) inputs never reach out.
  always_comb begin
    out_valid_d = in_valid;
    out_d       = out_q;
    if (in_valid) begin
      out_d = lut_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ascon_sbox.sv
// Scoreboard bench for ascon_sbox; inverse-map stimulus is added when
// ASCON_SBOX_INV_EN is defined.
module tb_ascon_sbox;

`ifdef ASCON_SBOX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [4:0] FWD [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_s     = '0;
  logic       inv_s    = 1'b0;
  logic       out_valid;
  logic [4:0] out_s;

  logic [4:0] exp_q [$];
  logic [4:0] inv_tab [32];
  logic [4:0] model_out = '0;
  logic       mon_v, mon_r;
  logic [4:0] mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ascon_sbox dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_s),
`ifdef ASCON_SBOX_INV_EN
    .inv       (inv_s),
`endif
    .out_valid (out_valid),
    .out       (out_s)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] model(input logic [4:0] d, input logic i);
    if (i && INV_EN) return inv_tab[d];
    return FWD[d];
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [4:0] d, input logic i);
    @(negedge clk);
    in_valid = v;
    in_s     = v ? d : 5'bx;
    inv_s    = v ? i : 1'bx;
    if (v) exp_q.push_back(model(d, i));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'h00, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    mon_v = in_valid;
    mon_r = rst;
    #1;
    if (mon_v === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 8'd1, 8'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_r && !rst) model_out = mon_e;
      end
    end
    if (rst) model_out = '0;
    check_eq("out_valid", {7'd0, out_valid}, {7'd0, (mon_v === 1'b1) && !mon_r && !rst});
    check_eq("out", {3'd0, out_s}, {3'd0, model_out});
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int x = 0; x < 32; x++) inv_tab[FWD[x]] = x[4:0];

    #1 rst = 1'b1;
    #1;
    check_eq("reset_out", {3'd0, out_s}, 8'h00);
    check_eq("reset_valid", {7'd0, out_valid}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First input after reset: 00 -> 04
    drive(1'b1, 5'h00, 1'b0);
    idle(1);

    // Full back-to-back sweep 00..1F
    for (int x = 0; x < 32; x++) drive(1'b1, x[4:0], 1'b0);
    idle(1);

    // Single input then idle with X on the ignored inputs: 05 -> 15 held
    drive(1'b1, 5'h05, 1'b0);
    idle(3);

    // Asynchronous reset between edges, mid-stream
    drive(1'b1, 5'h0A, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("async_rst_out", {3'd0, out_s}, 8'h00);
    check_eq("async_rst_valid", {7'd0, out_valid}, 8'h00);
    drive(1'b1, 5'h0B, 1'b0);  // sampled while rst high, must be dropped
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_s     = 5'bx;
    drive(1'b1, 5'h0C, 1'b0);  // first edge after reset is processed
    idle(1);

    // Random valid/data mix
    for (int k = 0; k < 60; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
    end
    idle(2);

`ifdef ASCON_SBOX_INV_EN
    drive(1'b1, 5'h04, 1'b1);
    idle(1);
    for (int x = 0; x < 32; x++) begin
      drive(1'b1, x[4:0], 1'b0);
      drive(1'b1, FWD[x], 1'b1);
    end
    idle(2);
`endif

    check_eq("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_sbox.md
ASCON_SBOX -- requirements
Module: ascon_sbox

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 in_valid  input  1  qualifies `in` for the current cycle.
REQ-005 in  input  5  S-box input word; bit 4 = x0 (MSB), bit 0 = x4.
REQ-006 inv  input  1  exists only with ASCON_SBOX_INV_EN; 1 selects the inverse S-box.
REQ-007 out_valid  output  1  registered; high for exactly one cycle per accepted input.
REQ-008 out  output  5  registered substitution result, same bit ordering as `in`.

Function
REQ-009 Forward map S[0..31] SHALL be the ASCON 5-bit S-box: 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17 (hex).
REQ-010 Realisation SHALL be either a constant table or the ASCON bitsliced logic (xor/and-not/xor); both SHALL match REQ-009 for all 32 inputs.
REQ-011 Latency SHALL be exactly one clock: in_valid=1 at edge N gives out=S[in] and out_valid=1 after edge N.
REQ-012 in_valid=0 at an edge SHALL clear out_valid and hold out at its previous value.
REQ-013 Back-to-back valid inputs SHALL produce back-to-back results, one per cycle, with no stall and no ready signal.
REQ-014 `in` and `inv` SHALL be ignored when in_valid=0; X on ignored inputs SHALL NOT propagate to out.
REQ-015 No combinational path from any input to any output.

Reset
REQ-016 rst=1 SHALL immediately force out=5'h00 and out_valid=0, independent of clk.
REQ-017 A valid input sampled on the same edge at which rst is high SHALL be discarded.
REQ-018 After rst deasserts, the first rising edge with in_valid=1 SHALL be processed normally.

Configuration
REQ-019 With macro ASCON_SBOX_INV_EN defined, port `inv` SHALL exist, and inv=1 SHALL select the inverse map Sinv[0..31]: 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02 (hex); `inv` is sampled with in_valid.
REQ-020 Without ASCON_SBOX_INV_EN, port `inv` SHALL be absent and only the forward map is built.

Structure
REQ-021 A shared package ascon_pkg SHALL hold the 5-bit word typedef and the forward and inverse S-box constant tables.
REQ-022 Combinational lookup SHALL be a sub-module ascon_sbox_lut (in, inv -> out, no state); ascon_sbox adds the valid and output registers.

Verification
REQ-023 Reset then in_valid=1, in=5'h00 -> one cycle later out=5'h04, out_valid=1.
REQ-024 Stream in=00..1F on consecutive cycles -> out follows REQ-009 one cycle late, out_valid continuously high; in=1F -> 17.
REQ-025 in_valid=1 in=05 then in_valid=0 for 3 cycles -> out=15 held, out_valid high for one cycle only.
REQ-026 Assert rst asynchronously mid-stream (between edges) -> out=00 and out_valid=0 immediately; no result for the input sampled during reset.
REQ-027 With ASCON_SBOX_INV_EN: inv=1, in=04 -> out=00; for all x, forward then inverse returns x.
